// File: rtl/drive_arbiter.sv
// drive_arbiter: hands the two motor drivers to the line follower (default owner),
// the crossing-turn sequencer or the station handler. Every change of ownership
// goes through a dead-time guard with both motors stopped, and a watchdog forces
// a task that runs too long back to the line follower.
module drive_arbiter #(
  parameter int GUARD_CYCLES = 50_000,       // stopped cycles on each handover
  parameter int TIMEOUT      = 100_000_000,  // longest task before forced return
  parameter int CNT_W        = 27            // must hold max(GUARD_CYCLES, TIMEOUT)
) (
  input  logic       clk,
  input  logic       reset,                  // synchronous, active-low
  input  logic       req_turn,
  input  logic       req_station,
  input  logic [3:0] lf_motor,               // {l_reset, l_dir, r_reset, r_dir}
  input  logic [3:0] tc_motor,
  input  logic [3:0] st_motor,
  input  logic       tc_done,
  input  logic       st_done,
  output logic       turn_go,
  output logic       station_go,
  output logic       line_follower_start,
  output logic [1:0] owner,
  output logic       timeout_err,
  output logic       motor_l_reset,
  output logic       motor_l_direction,
  output logic       motor_r_reset,
  output logic       motor_r_direction
);

  typedef enum logic [1:0] {S_LINE, S_GUARD_IN, S_TASK, S_GUARD_OUT} state_e;
  typedef enum logic [1:0] {OWN_LINE = 2'd0, OWN_TURN = 2'd1, OWN_STATION = 2'd2} owner_e;

  localparam logic [CNT_W-1:0] GUARD_LAST   = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [3:0]       MOTOR_STOP   = 4'b1010;  // both drivers held in reset

  state_e           r_state, w_state_next;
  owner_e           r_owner, w_owner_next;     // also serves as the task selection
  logic [CNT_W-1:0] r_cnt,   w_cnt_next;
  logic             r_timeout_err, w_timeout_err_next;
  logic             r_lf_start,    w_lf_start_next;
  logic             w_done;
  logic [3:0]       w_motor;

  // State and bookkeeping registers; reset wins over everything, also mid-task.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_LINE;
      r_owner       <= OWN_LINE;
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
      r_lf_start    <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_owner       <= w_owner_next;
      r_cnt         <= w_cnt_next;
      r_timeout_err <= w_timeout_err_next;
      r_lf_start    <= w_lf_start_next;
    end
  end

  // Only the done pulse of the task that owns the motors counts.
  assign w_done = (r_owner == OWN_STATION) ? st_done : tc_done;

  // Next-state logic: request arbitration, guard timing, done/watchdog return.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_state_next       = r_state;
    w_owner_next       = r_owner;
    w_cnt_next         = r_cnt;
    w_timeout_err_next = r_timeout_err;
    w_lf_start_next    = 1'b0;
    case (r_state)
      S_LINE: begin
        // The stale request is still high on the return cycle, so skip it.
        if (!r_lf_start && (req_station || req_turn)) begin
          w_owner_next = req_station ? OWN_STATION : OWN_TURN;
          w_cnt_next   = '0;
          w_state_next = S_GUARD_IN;
        end
      end
      S_GUARD_IN: begin
        if (r_cnt == GUARD_LAST) begin
          w_cnt_next   = '0;
          w_state_next = S_TASK;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      S_TASK: begin
        if (w_done) begin
          w_cnt_next   = '0;
          w_state_next = S_GUARD_OUT;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_cnt_next         = '0;
          w_timeout_err_next = 1'b1;
          w_state_next       = S_GUARD_OUT;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      S_GUARD_OUT: begin
        if (r_cnt == GUARD_LAST) begin
          w_cnt_next      = '0;
          w_owner_next    = OWN_LINE;
          w_lf_start_next = 1'b1;
          w_state_next    = S_LINE;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      default: w_state_next = S_LINE;
    endcase
  end

  // Motor mux: line follower by default, stopped during guards, task in TASK.
  always_comb begin
    w_motor = lf_motor;
    case (r_state)
      S_GUARD_IN, S_GUARD_OUT: w_motor = MOTOR_STOP;
      S_TASK:                  w_motor = (r_owner == OWN_STATION) ? st_motor : tc_motor;
      default:                 w_motor = lf_motor;
    endcase
  end

  assign turn_go             = (r_state == S_TASK) && (r_owner == OWN_TURN);
  assign station_go          = (r_state == S_TASK) && (r_owner == OWN_STATION);
  assign line_follower_start = r_lf_start;
  assign owner               = r_owner;
  assign timeout_err         = r_timeout_err;
  assign motor_l_reset       = w_motor[3];
  assign motor_l_direction   = w_motor[2];
  assign motor_r_reset       = w_motor[1];
  assign motor_r_direction   = w_motor[0];

endmodule

// File: tb/tb_drive_arbiter.sv
// tb_drive_arbiter: directed stimulus for drive_arbiter with GUARD_CYCLES=4 and
// TIMEOUT=20. Stimulus pushes expected events into a queue; a monitor pops and
// compares them when the DUT raises a go output, pulses line_follower_start, or
// the stimulus asks for a snapshot.
module tb_drive_arbiter;

  localparam int GUARD = 4;
  localparam int TMO   = 20;
  localparam logic [3:0] TC_CMD = 4'b0100;
  localparam logic [3:0] ST_CMD = 4'b0001;

  typedef enum int {EV_SNAP = 0, EV_GO = 1, EV_LFS = 2} ev_e;

  typedef struct {
    ev_e        kind;
    logic [1:0] owner;
    logic       turn_go;
    logic       station_go;
    logic [3:0] motors;
    logic       err;
    int         guard_len;
    int         task_len;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_turn = 1'b0, req_station = 1'b0;
  logic [3:0] lf_motor = 4'b0101, tc_motor = TC_CMD, st_motor = ST_CMD;
  logic       tc_done = 1'b0, st_done = 1'b0;
  logic       turn_go, station_go, line_follower_start, timeout_err;
  logic [1:0] owner;
  logic       motor_l_reset, motor_l_direction, motor_r_reset, motor_r_direction;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  int   snap_req = 0, snap_seen = 0;
  int   guard_run = 0, go_run = 0, guard_bad = 0;
  logic prev_go = 1'b0;

  drive_arbiter #(.GUARD_CYCLES(GUARD), .TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req_turn(req_turn), .req_station(req_station),
    .lf_motor(lf_motor), .tc_motor(tc_motor), .st_motor(st_motor),
    .tc_done(tc_done), .st_done(st_done), .turn_go(turn_go), .station_go(station_go),
    .line_follower_start(line_follower_start), .owner(owner), .timeout_err(timeout_err),
    .motor_l_reset(motor_l_reset), .motor_l_direction(motor_l_direction),
    .motor_r_reset(motor_r_reset), .motor_r_direction(motor_r_direction)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input ev_e kind, input logic [1:0] own, input logic tg,
                              input logic sg, input logic [3:0] mot, input logic err,
                              input int glen, input int tlen);
    exp_t e;
    e.kind = kind; e.owner = own; e.turn_go = tg; e.station_go = sg;
    e.motors = mot; e.err = err; e.guard_len = glen; e.task_len = tlen;
    return e;
  endfunction

  task automatic snap(input exp_t e);
    q.push_back(e);
    snap_req++;
    tick();
  endtask

  // which: 0 = turn_go, 1 = station_go, 2 = line_follower_start
  task automatic wait_sig(input int which, input int max_cycles);
    logic s;
    s = 1'b0;
    for (int n = 0; n < max_cycles && !s; n++) begin
      tick();
      s = (which == 0) ? turn_go : (which == 1) ? station_go : line_follower_start;
    end
    check($sformatf("wait_sig%0d", which), {31'd0, s}, 32'd1);
  endtask

  // Compare the current DUT outputs with the oldest expected event.
  task automatic compare_event(input ev_e kind);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event kind=%0d at %0t", kind, $time);
      return;
    end
    e = q.pop_front();
    check("event_kind", kind, e.kind);
    check("owner", {30'd0, owner}, {30'd0, e.owner});
    check("turn_go", {31'd0, turn_go}, {31'd0, e.turn_go});
    check("station_go", {31'd0, station_go}, {31'd0, e.station_go});
    check("motors", {28'd0, motor_l_reset, motor_l_direction, motor_r_reset, motor_r_direction},
          {28'd0, e.motors});
    check("timeout_err", {31'd0, timeout_err}, {31'd0, e.err});
    if (kind == EV_SNAP) begin
      check("lf_start_idle", {31'd0, line_follower_start}, 32'd0);
    end else begin
      check("guard_len", guard_run, e.guard_len);
      check("guard_motors_stopped_violations", guard_bad, 0);
      if (kind == EV_LFS) check("task_len", go_run, e.task_len);
    end
  endtask

  // Monitor: track guard/task run lengths and fire compares on DUT events.
  always @(negedge clk) begin
    logic go_now;
    go_now = turn_go | station_go;
    if (!reset) begin
      guard_run = 0; go_run = 0; guard_bad = 0; prev_go = 1'b0;
    end else begin
      if (go_now) go_run++;
      else if (owner != 2'd0) begin
        guard_run++;
        if ({motor_l_reset, motor_l_direction, motor_r_reset, motor_r_direction} != 4'b1010)
          guard_bad++;
      end
      if (go_now && !prev_go) begin
        compare_event(EV_GO);
        guard_run = 0; guard_bad = 0;
      end
      if (line_follower_start) begin
        compare_event(EV_LFS);
        guard_run = 0; guard_bad = 0; go_run = 0;
      end
      prev_go = go_now;
    end
    if (snap_req != snap_seen) begin
      snap_seen = snap_req;
      compare_event(EV_SNAP);
    end
  end

  initial begin
    // Reset held for three cycles; motors follow lf_motor while in reset.
    reset = 1'b0;
    repeat (3) tick();
    snap(mk(EV_SNAP, 2'd0, 1'b0, 1'b0, lf_motor, 1'b0, 0, 0));
    lf_motor = 4'b0011;
    snap(mk(EV_SNAP, 2'd0, 1'b0, 1'b0, 4'b0011, 1'b0, 0, 0));
    reset = 1'b1;
    repeat (2) tick();

    // Crossing turn, with a stray tc_done in GUARD_IN and a stray st_done in TASK.
    q.push_back(mk(EV_GO, 2'd1, 1'b1, 1'b0, TC_CMD, 1'b0, GUARD, 0));
    q.push_back(mk(EV_LFS, 2'd0, 1'b0, 1'b0, 4'b0011, 1'b0, GUARD, 4));
    req_turn = 1'b1;
    tick();
    tc_done = 1'b1;
    tick();
    tc_done = 1'b0;
    wait_sig(0, 20);
    st_done = 1'b1;
    tick();
    st_done = 1'b0;
    repeat (2) tick();
    tc_done = 1'b1;
    tick();
    tc_done = 1'b0;
    wait_sig(2, 20);
    req_turn = 1'b0;
    repeat (2) tick();
    snap(mk(EV_SNAP, 2'd0, 1'b0, 1'b0, 4'b0011, 1'b0, 0, 0));

    // Station with st_done on the last TASK cycle: done beats the watchdog.
    lf_motor = 4'b1100;
    q.push_back(mk(EV_GO, 2'd2, 1'b0, 1'b1, ST_CMD, 1'b0, GUARD, 0));
    q.push_back(mk(EV_LFS, 2'd0, 1'b0, 1'b0, 4'b1100, 1'b0, GUARD, TMO));
    req_station = 1'b1;
    wait_sig(1, 20);
    repeat (TMO - 1) tick();
    st_done = 1'b1;
    tick();
    st_done = 1'b0;
    wait_sig(2, 20);
    req_station = 1'b0;
    repeat (2) tick();
    snap(mk(EV_SNAP, 2'd0, 1'b0, 1'b0, 4'b1100, 1'b0, 0, 0));

    // Both requests: station wins, no done, watchdog fires after TMO cycles.
    lf_motor = 4'b1111;
    q.push_back(mk(EV_GO, 2'd2, 1'b0, 1'b1, ST_CMD, 1'b0, GUARD, 0));
    q.push_back(mk(EV_LFS, 2'd0, 1'b0, 1'b0, 4'b1111, 1'b1, GUARD, TMO));
    req_turn = 1'b1;
    req_station = 1'b1;
    wait_sig(1, 20);
    wait_sig(2, 40);
    req_turn = 1'b0;
    req_station = 1'b0;
    repeat (3) tick();
    snap(mk(EV_SNAP, 2'd0, 1'b0, 1'b0, 4'b1111, 1'b1, 0, 0));
    repeat (5) tick();
    snap(mk(EV_SNAP, 2'd0, 1'b0, 1'b0, 4'b1111, 1'b1, 0, 0));

    // Reset mid-TASK: straight back to LINE, error cleared, no return pulse.
    lf_motor = 4'b0101;
    q.push_back(mk(EV_GO, 2'd1, 1'b1, 1'b0, TC_CMD, 1'b1, GUARD, 0));
    req_turn = 1'b1;
    wait_sig(0, 20);
    repeat (2) tick();
    reset = 1'b0;
    req_turn = 1'b0;
    tick();
    snap(mk(EV_SNAP, 2'd0, 1'b0, 1'b0, 4'b0101, 1'b0, 0, 0));
    reset = 1'b1;
    repeat (3) tick();
    snap(mk(EV_SNAP, 2'd0, 1'b0, 1'b0, 4'b0101, 1'b0, 0, 0));
    repeat (2) tick();

    check("expected_events_left", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
